// File: rtl/adder_arbiter.sv
`default_nettype none
//==============================================================================
// Module : adder_arbiter
// Brief  : Round-robin ownership arbiter in front of one shared combinational
//          WIDTH-bit adder, with an optional hold watchdog.
// Rev    : 1.0  initial release
//==============================================================================
module adder_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   opa_flat,
    input  logic [N_REQ*WIDTH-1:0]   opb_flat,
    output logic [N_REQ-1:0]         gnt,
    output logic [WIDTH-1:0]         adder_a,
    output logic [WIDTH-1:0]         adder_b,
    input  logic [WIDTH-1:0]         adder_sum,
    output logic [WIDTH-1:0]         sum_o,
    output logic [$clog2(N_REQ)-1:0] owner_o,
    output logic                     busy_o,
    output logic                     timeout_o
);

    localparam int c_idx_w = $clog2(N_REQ);
    localparam int c_cnt_w = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    localparam logic [0:0] c_idle  = 1'b0;
    localparam logic [0:0] c_owned = 1'b1;

    localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(N_REQ - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last = (MAX_HOLD > 0) ? c_cnt_w'(MAX_HOLD - 1) : '1;
    localparam logic [N_REQ-1:0]   c_one       = N_REQ'(1);

    logic [0:0]         r_state;
    logic [N_REQ-1:0]   r_gnt;
    logic [c_idx_w-1:0] r_owner;
    logic [c_idx_w-1:0] r_rr_ptr;
    logic [c_cnt_w-1:0] r_hold_ctr;
    logic [N_REQ-1:0]   r_mask;
    logic               r_timeout;

    logic [WIDTH-1:0]   w_opa [N_REQ];
    logic [WIDTH-1:0]   w_opb [N_REQ];

    logic               w_owned;
    logic               w_release;
    logic               w_force;
    logic               w_arb;
    logic [N_REQ-1:0]   w_owner_oh;
    logic [c_idx_w-1:0] w_ptr_inc;
    logic [c_idx_w-1:0] w_ptr_arb;
    logic [N_REQ-1:0]   w_elig;
    logic [c_idx_w:0]   w_pick;
    logic               w_found;
    logic [c_idx_w-1:0] w_win;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_opa[gi] = opa_flat[gi*WIDTH +: WIDTH];
            assign w_opb[gi] = opb_flat[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // First set bit of elig scanning ptr, ptr+1, ... (mod N_REQ); MSB = found.
    function automatic logic [c_idx_w:0] f_pick(input logic [N_REQ-1:0]   elig,
                                                input logic [c_idx_w-1:0] ptr);
        int j;
        f_pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_REQ;
            if (elig[j]) begin
                f_pick = {1'b1, c_idx_w'(j)};
            end
        end
    endfunction

    always_comb begin
        w_owned    = (r_state == c_owned);
        w_owner_oh = c_one << r_owner;
        w_ptr_inc  = (r_owner == c_last_idx) ? '0 : r_owner + c_idx_w'(1);
        w_release  = w_owned && !req[r_owner];
        w_force    = (MAX_HOLD > 0) && w_owned && req[r_owner] && (r_hold_ctr == c_hold_last);
        w_arb      = !w_owned || w_release || w_force;
        w_ptr_arb  = (w_release || w_force) ? w_ptr_inc : r_rr_ptr;
        // A force-released owner still has req high, so exclude it explicitly.
        w_elig     = req & ~r_mask & ~(w_force ? w_owner_oh : '0);
        w_pick     = f_pick(w_elig, w_ptr_arb);
        w_found    = w_pick[c_idx_w];
        w_win      = w_pick[c_idx_w-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_idle;
            r_gnt      <= '0;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_hold_ctr <= '0;
            r_mask     <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_force;
            r_mask    <= (r_mask & req) | (w_force ? w_owner_oh : '0);
            if (w_release || w_force) begin
                r_rr_ptr <= w_ptr_inc;
            end
            if (w_arb) begin
                if (w_found) begin
                    r_state    <= c_owned;
                    r_gnt      <= c_one << w_win;
                    r_owner    <= w_win;
                    r_hold_ctr <= '0;
                end else begin
                    r_state <= c_idle;
                    r_gnt   <= '0;
                end
            end else if (r_hold_ctr != c_hold_last) begin
                r_hold_ctr <= r_hold_ctr + c_cnt_w'(1);
            end
        end
    end

    always_comb begin
        adder_a = w_owned ? w_opa[r_owner] : '0;
        adder_b = w_owned ? w_opb[r_owner] : '0;
    end

    assign sum_o     = adder_sum;
    assign gnt       = r_gnt;
    assign owner_o   = r_owner;
    assign busy_o    = w_owned;
    assign timeout_o = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
//==============================================================================
// Module : tb_adder_arbiter
// Brief  : Directed self-checking bench for adder_arbiter (N_REQ=4, WIDTH=16,
//          MAX_HOLD=32); the bench plays the role of the shared adder.
// Rev    : 1.0  initial release
//==============================================================================
module tb_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] opa_flat;
    logic [63:0] opb_flat;
    logic [3:0]  gnt;
    logic [15:0] adder_a;
    logic [15:0] adder_b;
    logic [15:0] adder_sum;
    logic [15:0] sum_o;
    logic [1:0]  owner_o;
    logic        busy_o;
    logic        timeout_o;

    int n_pass  = 0;
    int n_total = 0;

    adder_arbiter #(
        .N_REQ   (4),
        .WIDTH   (16),
        .MAX_HOLD(32)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .opa_flat (opa_flat),
        .opb_flat (opb_flat),
        .gnt      (gnt),
        .adder_a  (adder_a),
        .adder_b  (adder_b),
        .adder_sum(adder_sum),
        .sum_o    (sum_o),
        .owner_o  (owner_o),
        .busy_o   (busy_o),
        .timeout_o(timeout_o)
    );

    assign adder_sum = adder_a + adder_b;

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        req      = '0;
        opa_flat = '0;
        opb_flat = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        req      = '0;
        opa_flat = '0;
        opb_flat = '0;
        #1;
        n_total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got=%b exp=0000", gnt); else n_pass++;
        n_total++; if (busy_o !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_o); else n_pass++;
        n_total++; if (owner_o !== 2'd0) $display("FAIL reset_owner got=%0d exp=0", owner_o); else n_pass++;
        n_total++; if (timeout_o !== 1'b0) $display("FAIL reset_timeout got=%b exp=0", timeout_o); else n_pass++;
        n_total++; if (adder_a !== 16'h0000) $display("FAIL reset_adder_a got=%h exp=0000", adder_a); else n_pass++;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_basic;
        do_reset();
        opa_flat[15:0] = 16'h1234;
        opb_flat[15:0] = 16'h0F0F;
        req            = 4'b0001;
        #1;
        n_total++; if (gnt !== 4'b0000) $display("FAIL basic_latency got=%b exp=0000", gnt); else n_pass++;
        tick();
        n_total++; if (gnt !== 4'b0001) $display("FAIL basic_gnt got=%b exp=0001", gnt); else n_pass++;
        n_total++; if (owner_o !== 2'd0) $display("FAIL basic_owner got=%0d exp=0", owner_o); else n_pass++;
        n_total++; if (busy_o !== 1'b1) $display("FAIL basic_busy got=%b exp=1", busy_o); else n_pass++;
        n_total++; if (adder_a !== 16'h1234) $display("FAIL basic_adder_a got=%h exp=1234", adder_a); else n_pass++;
        n_total++; if (adder_b !== 16'h0F0F) $display("FAIL basic_adder_b got=%h exp=0f0f", adder_b); else n_pass++;
        n_total++; if (sum_o !== 16'h2143) $display("FAIL basic_sum got=%h exp=2143", sum_o); else n_pass++;
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_gnt;
        do_reset();
        req = 4'b1111;
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_gnt = 4'b0001 << i;
            for (int c = 0; c < 3; c++) begin
                n_total++;
                if (gnt !== exp_gnt) $display("FAIL rr_hold owner=%0d cyc=%0d got=%b exp=%b", i, c, gnt, exp_gnt);
                else n_pass++;
                if (c < 2) tick();
            end
            req[i] = 1'b0;
            if (i == 3) req[0] = 1'b1;
            tick();
        end
        n_total++; if (gnt !== 4'b0001) $display("FAIL rr_wrap_gnt got=%b exp=0001", gnt); else n_pass++;
        n_total++; if (owner_o !== 2'd0) $display("FAIL rr_wrap_owner got=%0d exp=0", owner_o); else n_pass++;
    endtask

    task automatic test_watchdog;
        int cnt;
        do_reset();
        req = 4'b0100;
        tick();
        n_total++; if (gnt !== 4'b0100) $display("FAIL wd_first_gnt got=%b exp=0100", gnt); else n_pass++;
        req = 4'b0110;
        cnt = 1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (gnt == 4'b0100) cnt++;
            else break;
        end
        n_total++; if (cnt != 32) $display("FAIL wd_hold_cycles got=%0d exp=32", cnt); else n_pass++;
        n_total++; if (gnt !== 4'b0010) $display("FAIL wd_handover_gnt got=%b exp=0010", gnt); else n_pass++;
        n_total++; if (timeout_o !== 1'b1) $display("FAIL wd_timeout_pulse got=%b exp=1", timeout_o); else n_pass++;
        n_total++; if (owner_o !== 2'd1) $display("FAIL wd_owner got=%0d exp=1", owner_o); else n_pass++;
        tick();
        n_total++; if (timeout_o !== 1'b0) $display("FAIL wd_timeout_end got=%b exp=0", timeout_o); else n_pass++;
        n_total++; if (gnt !== 4'b0010) $display("FAIL wd_keep_gnt got=%b exp=0010", gnt); else n_pass++;
        req = 4'b0100;
        tick();
        n_total++; if (gnt !== 4'b0000) $display("FAIL wd_masked_gnt got=%b exp=0000", gnt); else n_pass++;
        n_total++; if (busy_o !== 1'b0) $display("FAIL wd_masked_busy got=%b exp=0", busy_o); else n_pass++;
        tick();
        n_total++; if (gnt !== 4'b0000) $display("FAIL wd_still_masked got=%b exp=0000", gnt); else n_pass++;
        req = 4'b0000;
        tick();
        req = 4'b0100;
        tick();
        n_total++; if (gnt !== 4'b0100) $display("FAIL wd_regrant got=%b exp=0100", gnt); else n_pass++;
    endtask

    task automatic test_wrap;
        do_reset();
        opa_flat[15:0]  = 16'hFFFF;
        opb_flat[15:0]  = 16'h0002;
        opa_flat[63:48] = 16'h8000;
        opb_flat[63:48] = 16'h8003;
        req = 4'b0001;
        tick();
        n_total++; if (adder_a !== 16'hFFFF) $display("FAIL wrap_adder_a got=%h exp=ffff", adder_a); else n_pass++;
        n_total++; if (sum_o !== 16'h0001) $display("FAIL wrap_sum0 got=%h exp=0001", sum_o); else n_pass++;
        req = 4'b1000;
        tick();
        n_total++; if (gnt !== 4'b1000) $display("FAIL wrap_gnt3 got=%b exp=1000", gnt); else n_pass++;
        n_total++; if (adder_b !== 16'h8003) $display("FAIL wrap_adder_b3 got=%h exp=8003", adder_b); else n_pass++;
        n_total++; if (sum_o !== 16'h0003) $display("FAIL wrap_sum3 got=%h exp=0003", sum_o); else n_pass++;
        req = 4'b0000;
        tick();
        n_total++; if (adder_a !== 16'h0000) $display("FAIL idle_adder_a got=%h exp=0000", adder_a); else n_pass++;
        n_total++; if (adder_b !== 16'h0000) $display("FAIL idle_adder_b got=%h exp=0000", adder_b); else n_pass++;
        n_total++; if (sum_o !== 16'h0000) $display("FAIL idle_sum got=%h exp=0000", sum_o); else n_pass++;
        n_total++; if (owner_o !== 2'd3) $display("FAIL idle_owner_hold got=%0d exp=3", owner_o); else n_pass++;
    endtask

    task automatic test_async_reset;
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0010;
        tick();
        n_total++; if (gnt !== 4'b0010) $display("FAIL ar_pre_gnt got=%b exp=0010", gnt); else n_pass++;
        #3;
        rst = 1'b1;
        #1;
        n_total++; if (gnt !== 4'b0000) $display("FAIL ar_gnt_drop got=%b exp=0000", gnt); else n_pass++;
        n_total++; if (busy_o !== 1'b0) $display("FAIL ar_busy_drop got=%b exp=0", busy_o); else n_pass++;
        n_total++; if (owner_o !== 2'd0) $display("FAIL ar_owner got=%0d exp=0", owner_o); else n_pass++;
        req = 4'b0101;
        tick();
        rst = 1'b0;
        tick();
        n_total++; if (gnt !== 4'b0001) $display("FAIL ar_ptr_restart got=%b exp=0001", gnt); else n_pass++;
        req = 4'b0100;
        tick();
        n_total++; if (gnt !== 4'b0100) $display("FAIL ar_gnt2 got=%b exp=0100", gnt); else n_pass++;
        n_total++; if (owner_o !== 2'd2) $display("FAIL ar_owner2 got=%0d exp=2", owner_o); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_watchdog();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
